uart_transceiver_param: RTL and testbench
=========================================

// Module: uart_transceiver_param
// PURPOSE
//  Parametrised full-duplex UART (Tx + Rx) and the successor to the fixed 8-bit, even-parity core.
//  Adds configurable data width, parity mode, stop-bit count, Rx valid/ready hold and error flags.
//  Adds a runtime loopback select that routes Tx to Rx internally for self-test.
//  Sits between the host register interface and the pad pair.
// PARAMETERS
//  DATA_WIDTH     8   data bits per frame, 5..9
//  PARITY_MODE    1   0 = none, 1 = even, 2 = odd
//  STOP_BITS      1   1 or 2
//  CLKS_PER_BIT   8   clk cycles per bit; even, >= 4
//  SYNC_STAGES    3   serial_in synchroniser depth, >= 2
// PORTS
//  clk            in   1           single system clock
//  reset          in   1           asynchronous, active-low reset
//  enable         in   1           Tx request; accepted only when o_busy == 0
//  i_data         in   DATA_WIDTH  Tx payload, sampled on the accept cycle
//  o_busy         out  1           Tx frame pending or in flight
//  serial_out     out  1           Tx line, idle high
//  serial_in      in   1           Rx line, asynchronous
//  loopback       in   1           1 = Rx takes serial_out internally; serial_in is ignored
//  rx_ready       in   1           consumer takes received_data while data_is_valid == 1
//  received_data  out  DATA_WIDTH  last good frame payload
//  data_is_valid  out  1           held high until rx_ready; cleared the cycle after handshake
//  rx_error       out  1           parity mismatch; 1-cycle pulse
//  frame_error    out  1           stop bit sampled low; 1-cycle pulse
//  overrun        out  1           new frame done while data_is_valid still high; 1-cycle pulse
// BEHAVIOUR
//  Reset: serial_out = 1; o_busy, data_is_valid, rx_error, frame_error, overrun = 0.
//   received_data = 0; synchroniser flops = 1; both FSMs go to IDLE.
//   Reset mid-frame aborts immediately, with no partial output.
//  Tx frame: start(0), data bits LSB first, parity bit if PARITY_MODE != 0, then STOP_BITS x 1.
//   NBITS = 1 + DATA_WIDTH + (PARITY_MODE != 0) + STOP_BITS.
//   Even parity bit = ^data. Odd parity bit = ~^data.
//  Tx handshake: enable && !o_busy at edge t latches i_data.
//   o_busy = 1 from t+1; serial_out start bit from t+1.
//   Each bit is held exactly CLKS_PER_BIT clocks; the bit counter restarts on accept (no free-running baud phase).
//   o_busy falls after the last stop-bit clock, i.e. t+1+NBITS*CLKS_PER_BIT.
//   enable while o_busy is ignored. A back-to-back accept is legal on the o_busy-fall edge.
//  Tx FSM: IDLE -> START -> DATA(DATA_WIDTH) -> PARITY (skipped if none) -> STOP(STOP_BITS) -> IDLE.
//  Rx input: rx_line = loopback ? serial_out : serial_in, then passed through SYNC_STAGES flops.
//  Rx FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
//   IDLE: synced line 1->0 starts the counter; sample at CLKS_PER_BIT/2.
//   START: if the mid-start sample is 1 -> false start, return to IDLE with no flags.
//   DATA: one sample per bit at mid-bit; shift right into a DATA_WIDTH register (LSB first).
//   STOP: only the first stop bit is checked. Rx returns to IDLE at that mid-bit sample and does not wait for a second stop bit.
//  Rx completion, at the first stop mid-sample cycle s (outputs registered, visible at s+1):
//   stop == 0: frame_error pulses; data is discarded; Rx waits for line == 1 before re-arming.
//   stop == 1 with parity bad: rx_error pulses; data is discarded.
//   Good frame with data_is_valid == 0: received_data loads and data_is_valid is set.
//   Good frame with data_is_valid == 1 and no handshake this cycle: overrun pulses; old data is kept.
//   Good frame with data_is_valid == 1 and rx_ready high this cycle: new data loads and valid stays 1.
//  Toggling loopback mid-frame is permitted. Rx may flag frame_error or rx_error but must resynchronise on the next idle-high line.
//  Loopback latency: the good frame's data_is_valid rises within SYNC_STAGES + 2 clocks after
//   the mid-point of Tx's first stop bit.
// STRUCTURE
//  uart_pkg: parity enum (PAR_NONE/EVEN/ODD), Tx/Rx state enums, function frame_bits().
//  Sub-module uart_bit_timer: a CLKS_PER_BIT counter with restart, a mid-bit strobe and an end-of-bit strobe.
//   Instantiated once in Tx and once in Rx.
//  Tx and Rx FSMs live in this file; the synchroniser is an inline shift register.
// TESTING
//  1. Loopback, defaults, enable with i_data=8'hA5 -> serial_out emits 0,1,0,1,0,0,1,0,1,0(parity),1.
//     Each bit lasts 8 clks; data_is_valid=1 with received_data=8'hA5; rx_error=0.
//  2. PARITY_MODE=2, STOP_BITS=2, DATA_WIDTH=7, i_data=7'h00 -> parity bit 1.
//     o_busy high for exactly 11*CLKS_PER_BIT clks.
//  3. Hold rx_ready=0 and send 8'h11 then 8'h22 -> overrun pulses once; received_data stays 8'h11.
//  4. External serial_in with the stop bit forced 0 -> frame_error pulse, data_is_valid stays 0.
//     The next clean frame 8'h3C is received correctly.
//  5. A 2-clk low glitch on serial_in -> no state exit past START, no flags.
//     A parity-flipped frame gives an rx_error pulse only.
//  6. Assert reset mid-DATA (bit 4) -> serial_out=1, o_busy=0 asynchronously.
//     After release, enable 8'hFF is accepted and 8'hFF is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transceiver.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   // RX_WAIT_HIGH parks the receiver after a framing error until the line idles high.
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

   // Total bits on the wire for one frame: start + data + optional parity + stops.
   function automatic int unsigned frame_bits(input int unsigned dw,
                                              input int unsigned pm,
                                              input int unsigned sb);
      return 1 + dw + ((pm != 0) ? 1 : 0) + sb;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with restart, a mid-bit strobe and an end-of-bit strobe.
// Latency: restart takes effect on the next clock; strobes are combinational from the count.
// Backpressure: none; counts whenever run is high.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic run,
   output logic mid_stb,
   output logic end_stb
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign end_stb = run && (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign mid_stb = run && (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));

   // Next count: restart wins, otherwise wrap at the end of each bit period.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = end_stb ? '0 : cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transceiver_param.sv
// Full-duplex UART with configurable width, parity, stop bits and internal loopback.
// Latency: Tx line starts the clock after accept; Rx result appears SYNC_STAGES+1 clocks after the stop mid-bit on the line.
// Backpressure: Tx accepts only while o_busy is low; Rx holds data_is_valid until rx_ready, flagging overrun otherwise.
module uart_transceiver_param
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int PARITY_MODE  = 1,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 8,
   parameter int SYNC_STAGES  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_busy,
   output logic                  serial_out,
   input  logic                  serial_in,
   input  logic                  loopback,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] received_data,
   output logic                  data_is_valid,
   output logic                  rx_error,
   output logic                  frame_error,
   output logic                  overrun
);

   localparam parity_e PMODE = parity_e'(PARITY_MODE);
   localparam int NBITS      = frame_bits(DATA_WIDTH, PARITY_MODE, STOP_BITS);
   localparam int IW         = $clog2(NBITS + 1);

   // ---------------- Tx ----------------
   tx_state_e             tx_state_q, tx_state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  tx_par_q, tx_par_d;
   logic [IW-1:0]         tx_idx_q, tx_idx_d;
   logic                  serial_out_q, serial_out_d;
   logic                  tx_restart, tx_end, tx_mid_unused;
   logic                  i_par;

   assign i_par = (PMODE == PAR_ODD) ? ~(^i_data) : ^i_data;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (tx_restart),
      .run     (tx_state_q != TX_IDLE),
      .mid_stb (tx_mid_unused),
      .end_stb (tx_end)
   );

   // Tx next-state: serial_out_d is the level for the bit that starts after this edge.
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_shift_d   = tx_shift_q;
      tx_par_d     = tx_par_q;
      tx_idx_d     = tx_idx_q;
      serial_out_d = serial_out_q;
      tx_restart   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            serial_out_d = 1'b1;
            if (enable) begin
               tx_shift_d   = i_data;
               tx_par_d     = i_par;
               tx_restart   = 1'b1;
               serial_out_d = 1'b0;
               tx_state_d   = TX_START;
            end
         end
         TX_START: begin
            if (tx_end) begin
               tx_state_d   = TX_DATA;
               tx_idx_d     = '0;
               serial_out_d = tx_shift_q[0];
            end
         end
         TX_DATA: begin
            if (tx_end) begin
               tx_shift_d = tx_shift_q >> 1;
               if (tx_idx_q == IW'(DATA_WIDTH - 1)) begin
                  tx_idx_d = '0;
                  if (PMODE == PAR_NONE) begin
                     tx_state_d   = TX_STOP;
                     serial_out_d = 1'b1;
                  end else begin
                     tx_state_d   = TX_PARITY;
                     serial_out_d = tx_par_q;
                  end
               end else begin
                  tx_idx_d     = tx_idx_q + IW'(1);
                  serial_out_d = tx_shift_q[1];
               end
            end
         end
         TX_PARITY: begin
            if (tx_end) begin
               tx_state_d   = TX_STOP;
               tx_idx_d     = '0;
               serial_out_d = 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_end) begin
               serial_out_d = 1'b1;
               if (tx_idx_q == IW'(STOP_BITS - 1)) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_idx_d = tx_idx_q + IW'(1);
               end
            end
         end
         default: begin
            tx_state_d   = TX_IDLE;
            serial_out_d = 1'b1;
         end
      endcase
   end

   // Tx state and line registers; reset drives the line idle high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q   <= TX_IDLE;
         tx_shift_q   <= '0;
         tx_par_q     <= 1'b0;
         tx_idx_q     <= '0;
         serial_out_q <= 1'b1;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_shift_q   <= tx_shift_d;
         tx_par_q     <= tx_par_d;
         tx_idx_q     <= tx_idx_d;
         serial_out_q <= serial_out_d;
      end
   end

   assign serial_out = serial_out_q;
   assign o_busy     = (tx_state_q != TX_IDLE);

   // ---------------- Rx ----------------
   logic                   rx_line, rx_s;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   rx_state_e              rx_state_q, rx_state_d;
   logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
   logic                   rx_par_q, rx_par_d;
   logic [IW-1:0]          rx_idx_q, rx_idx_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   dv_q, dv_d;
   logic                   rx_err_q, rx_err_d;
   logic                   frm_err_q, frm_err_d;
   logic                   ovr_q, ovr_d;
   logic                   rx_restart, rx_mid, rx_end_unused, rx_run;
   logic                   par_ok;

   assign rx_line = loopback ? serial_out_q : serial_in;
   assign sync_d  = {sync_q[SYNC_STAGES-2:0], rx_line};
   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign rx_run  = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);

   always_comb begin
      case (PMODE)
         PAR_EVEN: par_ok = ((^rx_shift_q) ^ rx_par_q) == 1'b0;
         PAR_ODD:  par_ok = ((^rx_shift_q) ^ rx_par_q) == 1'b1;
         default:  par_ok = 1'b1;
      endcase
   end

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (rx_restart),
      .run     (rx_run),
      .mid_stb (rx_mid),
      .end_stb (rx_end_unused)
   );

   // Rx next-state: mid-bit sampling, completion checks and the valid/ready hold.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      rx_idx_d   = rx_idx_q;
      rdata_d    = rdata_q;
      dv_d       = dv_q;
      rx_err_d   = 1'b0;
      frm_err_d  = 1'b0;
      ovr_d      = 1'b0;
      rx_restart = 1'b0;
      if (dv_q && rx_ready) begin
         dv_d = 1'b0;
      end
      case (rx_state_q)
         RX_IDLE: begin
            // Idle is only entered with the line high, so a low level here is a falling edge.
            if (!rx_s) begin
               rx_restart = 1'b1;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_mid) begin
               if (rx_s) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_idx_d   = '0;
               end
            end
         end
         RX_DATA: begin
            if (rx_mid) begin
               rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
               if (rx_idx_q == IW'(DATA_WIDTH - 1)) begin
                  rx_state_d = (PMODE == PAR_NONE) ? RX_STOP : RX_PARITY;
               end else begin
                  rx_idx_d = rx_idx_q + IW'(1);
               end
            end
         end
         RX_PARITY: begin
            if (rx_mid) begin
               rx_par_d   = rx_s;
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_mid) begin
               if (!rx_s) begin
                  frm_err_d  = 1'b1;
                  rx_state_d = RX_WAIT_HIGH;
               end else begin
                  rx_state_d = RX_IDLE;
                  if (!par_ok) begin
                     rx_err_d = 1'b1;
                  end else if (!dv_q || rx_ready) begin
                     rdata_d = rx_shift_q;
                     dv_d    = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_s) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Rx registers, including the synchroniser which resets to the idle-high level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q     <= '1;
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_idx_q   <= '0;
         rdata_q    <= '0;
         dv_q       <= 1'b0;
         rx_err_q   <= 1'b0;
         frm_err_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_idx_q   <= rx_idx_d;
         rdata_q    <= rdata_d;
         dv_q       <= dv_d;
         rx_err_q   <= rx_err_d;
         frm_err_q  <= frm_err_d;
         ovr_q      <= ovr_d;
      end
   end

   assign received_data = rdata_q;
   assign data_is_valid = dv_q;
   assign rx_error      = rx_err_q;
   assign frame_error   = frm_err_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_transceiver_param.sv
// Directed bench for the parametrised UART: default instance plus a 7-bit, odd-parity, 2-stop instance.
// Latency: n/a.
// Backpressure: rx_ready driven directly by the stimulus.
module tb_uart_transceiver_param;

   localparam int CPB = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;

   // default instance
   logic       enable = 1'b0;
   logic [7:0] i_data = 8'h00;
   logic       serial_in = 1'b1;
   logic       loopback = 1'b1;
   logic       rx_ready = 1'b0;
   logic       o_busy, serial_out, data_is_valid, rx_error, frame_error, overrun;
   logic [7:0] received_data;

   // 7-bit odd-parity two-stop instance
   logic       enable2 = 1'b0;
   logic [6:0] i_data2 = 7'h00;
   logic       serial_in2 = 1'b1;
   logic       loopback2 = 1'b1;
   logic       rx_ready2 = 1'b0;
   logic       o_busy2, serial_out2, dv2, rxe2, fe2, ov2;
   logic [6:0] rxd2;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rxe = 0;
   int n_fe  = 0;
   int n_ov  = 0;
   int n_err2 = 0;

   uart_transceiver_param u_dut (
      .clk (clk), .reset (reset), .enable (enable), .i_data (i_data),
      .o_busy (o_busy), .serial_out (serial_out), .serial_in (serial_in),
      .loopback (loopback), .rx_ready (rx_ready), .received_data (received_data),
      .data_is_valid (data_is_valid), .rx_error (rx_error),
      .frame_error (frame_error), .overrun (overrun)
   );

   uart_transceiver_param #(
      .DATA_WIDTH (7), .PARITY_MODE (2), .STOP_BITS (2), .CLKS_PER_BIT (8), .SYNC_STAGES (3)
   ) u_dut2 (
      .clk (clk), .reset (reset), .enable (enable2), .i_data (i_data2),
      .o_busy (o_busy2), .serial_out (serial_out2), .serial_in (serial_in2),
      .loopback (loopback2), .rx_ready (rx_ready2), .received_data (rxd2),
      .data_is_valid (dv2), .rx_error (rxe2), .frame_error (fe2), .overrun (ov2)
   );

   always #5 clk = ~clk;

   // Running pulse counts; the stimulus compares deltas across each step.
   always @(negedge clk) begin
      if (rx_error)    n_rxe  <= n_rxe + 1;
      if (frame_error) n_fe   <= n_fe + 1;
      if (overrun)     n_ov   <= n_ov + 1;
      if (rxe2 || fe2 || ov2) n_err2 <= n_err2 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive enable for one cycle; returns at the first cycle after the accepting edge.
   task automatic send_tx(input logic [7:0] d);
      int k = 0;
      while (o_busy && k < 200) begin @(negedge clk); k++; end
      if (o_busy) check("tx_idle_timeout", o_busy, 1'b0);
      enable = 1'b1;
      i_data = d;
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic wait_tx_done(input string tag);
      int k = 0;
      while (o_busy && k < 200) begin @(negedge clk); k++; end
      check(tag, o_busy, 1'b0);
   endtask

   task automatic wait_dv(input string tag);
      int k = 0;
      while (!data_is_valid && k < 200) begin @(negedge clk); k++; end
      check(tag, data_is_valid, 1'b1);
   endtask

   task automatic handshake(input string tag);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check(tag, data_is_valid, 1'b0);
   endtask

   // External 8-bit even-parity frame on serial_in.
   task automatic send_ext(input logic [7:0] d, input logic stop_v, input logic flip_par);
      serial_in = 1'b0;
      cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         serial_in = d[i];
         cyc(CPB);
      end
      serial_in = (^d) ^ flip_par;
      cyc(CPB);
      serial_in = stop_v;
      cyc(CPB);
      serial_in = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] exp1;
      logic [10:0] exp2;
      int b_rxe, b_fe, b_ov;

      // ---- reset state ----
      cyc(3);
      check("rst_serial_out", serial_out, 1'b1);
      check("rst_busy", o_busy, 1'b0);
      check("rst_dv", data_is_valid, 1'b0);
      check("rst_rxd", received_data, 8'h00);
      check("rst_flags", {rx_error, frame_error, overrun}, 3'b000);
      check("rst_busy2", o_busy2, 1'b0);
      reset = 1'b1;
      cyc(2);

      // ---- 1: loopback A5, bit-exact waveform ----
      exp1  = {1'b1, 1'b0, 8'hA5, 1'b0};
      b_rxe = n_rxe;
      send_tx(8'hA5);
      for (int c = 1; c <= 88; c++) begin
         check($sformatf("t1_bit_c%0d", c), serial_out, exp1[(c-1)/8]);
         check($sformatf("t1_busy_c%0d", c), o_busy, 1'b1);
         @(negedge clk);
      end
      check("t1_busy_fall", o_busy, 1'b0);
      check("t1_idle_line", serial_out, 1'b1);
      @(negedge clk);
      check("t1_dv_latency", data_is_valid, 1'b1);
      check("t1_rxd", received_data, 8'hA5);
      check("t1_no_rxerr", n_rxe - b_rxe, 0);
      handshake("t1_dv_clear");

      // ---- 3: overrun with rx_ready held low ----
      b_ov = n_ov;
      send_tx(8'h11);
      wait_tx_done("t3_tx1_done");
      wait_dv("t3_dv1");
      check("t3_rxd1", received_data, 8'h11);
      send_tx(8'h22);
      wait_tx_done("t3_tx2_done");
      cyc(10);
      check("t3_overrun_once", n_ov - b_ov, 1);
      check("t3_rxd_kept", received_data, 8'h11);
      check("t3_dv_held", data_is_valid, 1'b1);
      handshake("t3_dv_clear");

      // ---- 4: external frame with stop forced low, then clean 3C ----
      loopback = 1'b0;
      cyc(4);
      b_fe  = n_fe;
      b_rxe = n_rxe;
      send_ext(8'h5A, 1'b0, 1'b0);
      cyc(3 * CPB);
      check("t4_frame_err", n_fe - b_fe, 1);
      check("t4_dv_low", data_is_valid, 1'b0);
      check("t4_no_rxerr", n_rxe - b_rxe, 0);
      send_ext(8'h3C, 1'b1, 1'b0);
      cyc(6);
      check("t4_dv_3c", data_is_valid, 1'b1);
      check("t4_rxd_3c", received_data, 8'h3C);
      handshake("t4_dv_clear");

      // ---- 5: short glitch, then parity-flipped frame ----
      b_fe  = n_fe;
      b_rxe = n_rxe;
      b_ov  = n_ov;
      serial_in = 1'b0;
      cyc(2);
      serial_in = 1'b1;
      cyc(20);
      check("t5_glitch_flags", (n_fe - b_fe) + (n_rxe - b_rxe) + (n_ov - b_ov), 0);
      check("t5_glitch_dv", data_is_valid, 1'b0);
      send_ext(8'h96, 1'b1, 1'b1);
      cyc(4);
      check("t5_rxerr", n_rxe - b_rxe, 1);
      check("t5_no_fe", n_fe - b_fe, 0);
      check("t5_no_ov", n_ov - b_ov, 0);
      check("t5_dv_low", data_is_valid, 1'b0);
      check("t5_rxd_kept", received_data, 8'h3C);

      // ---- 6: reset during data bit 4, then FF ----
      loopback = 1'b1;
      cyc(4);
      send_tx(8'hFF);
      cyc(43);
      check("t6_in_frame", o_busy, 1'b1);
      reset = 1'b0;
      #1;
      check("t6_rst_line", serial_out, 1'b1);
      check("t6_rst_busy", o_busy, 1'b0);
      check("t6_rst_rxd", received_data, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      cyc(2);
      b_rxe = n_rxe;
      b_fe  = n_fe;
      check("t6_dv_after_rst", data_is_valid, 1'b0);
      send_tx(8'hFF);
      wait_tx_done("t6_tx_done");
      wait_dv("t6_dv");
      check("t6_rxd_ff", received_data, 8'hFF);
      check("t6_no_flags", (n_rxe - b_rxe) + (n_fe - b_fe), 0);
      handshake("t6_dv_clear");

      // ---- 2: 7-bit odd parity two stops on second instance ----
      exp2 = {1'b1, 1'b1, 1'b1, 7'h00, 1'b0};
      check("t2_idle_busy", o_busy2, 1'b0);
      i_data2 = 7'h00;
      enable2 = 1'b1;
      @(negedge clk);
      enable2 = 1'b0;
      for (int c = 1; c <= 88; c++) begin
         check($sformatf("t2_bit_c%0d", c), serial_out2, exp2[(c-1)/8]);
         check($sformatf("t2_busy_c%0d", c), o_busy2, 1'b1);
         @(negedge clk);
      end
      check("t2_busy_fall", o_busy2, 1'b0);
      begin
         int k = 0;
         while (!dv2 && k < 50) begin @(negedge clk); k++; end
      end
      check("t2_dv", dv2, 1'b1);
      check("t2_rxd", rxd2, 7'h00);
      check("t2_no_flags", n_err2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
